// File: rtl/arbiter_rr.sv
// arbiter_rr
// Grants one of NUM_M managers access to a single subordinate. Request and
// response grants are tracked separately so requests can be pipelined. A
// response queue records the grant order of accepted requests; the next grant
// is only issued while the queue still has room for it.
//
// Ports
//   clk            system clock
//   rst_n          synchronous, active-low reset
//   g_want         bitmask of managers requesting a grant
//   req_accepted   request handshake at the subordinate; releases g_req
//   resp_accepted  response handshake; releases g_resp
//   g_req          manager holding the request bus (NUM_M = idle)
//   g_resp         manager owed the oldest response (NUM_M = none)
//   outstanding    number of queued response grants
module arbiter_rr #(
   parameter int unsigned NUM_M           = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned RR_MODE         = 1,
   parameter int unsigned HOLD_OFF        = 1,
   localparam int unsigned G_BITS = $clog2(NUM_M + 1),
   localparam int unsigned C_BITS = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_M-1:0]  g_want,
   input  logic              req_accepted,
   input  logic              resp_accepted,
   output logic [G_BITS-1:0] g_req,
   output logic [G_BITS-1:0] g_resp,
   output logic [C_BITS-1:0] outstanding
);

   localparam int unsigned P_BITS = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [G_BITS-1:0] IDLE = G_BITS'(NUM_M);

   logic [G_BITS-1:0]   last;
   logic [G_BITS-1:0]   queue [MAX_OUTSTANDING];
   logic [P_BITS-1:0]   wr_ptr;
   logic [P_BITS-1:0]   rd_ptr;
   logic [C_BITS-1:0]   cnt;

   logic                push;
   logic                pop;
   logic                rel;
   logic                space;
   logic                found;
   logic [C_BITS:0]     cnt_next;
   logic [NUM_M-1:0]    eligible;
   logic [2*NUM_M-1:0]  dbl;
   logic [NUM_M-1:0]    rot;
   int unsigned         base;
   int unsigned         idx;
   logic [G_BITS-1:0]   winner;

   always_comb begin
      push     = req_accepted && (g_req != IDLE);
      pop      = resp_accepted && (cnt != '0);
      cnt_next = {1'b0, cnt} + (C_BITS+1)'(push) - (C_BITS+1)'(pop);
      rel      = (g_req == IDLE) || req_accepted;
      // Space is judged on the post-edge count, so a same-cycle response
      // frees a slot for the grant being chosen now.
      space    = cnt_next < (C_BITS+1)'(MAX_OUTSTANDING);

      for (int unsigned i = 0; i < NUM_M; i++) begin
         eligible[i] = g_want[i] && space &&
                       !((HOLD_OFF != 0) && (g_req == G_BITS'(i)));
      end

      // Rotate the eligible mask so that bit 0 is the first index searched;
      // fixed priority simply starts at index 0.
      base = (RR_MODE != 0) ? 32'(last) + 1 : 0;
      if (base >= NUM_M) begin
         base = 0;
      end
      dbl = {eligible, eligible} >> base;
      rot = dbl[NUM_M-1:0];

      winner = IDLE;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_M; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            idx   = base + k;
            if (idx >= NUM_M) begin
               idx = idx - NUM_M;
            end
            winner = G_BITS'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_req  <= IDLE;
         last   <= G_BITS'(NUM_M - 1);
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            queue[i] <= '0;
         end
      end else begin
         if (rel) begin
            g_req <= winner;
            if (found) begin
               last <= winner;
            end
         end
         if (push) begin
            queue[wr_ptr] <= g_req;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cnt <= cnt_next[C_BITS-1:0];
      end
   end

   always_comb begin
      g_resp      = (cnt == '0) ? IDLE : queue[rd_ptr];
      outstanding = cnt;
   end

endmodule
